axis_word_packetizer: RTL

// - Converts a stream of WORD_WIDTH-bit result words (e.g. GCC-PHAT lag/peak values) into a framed byte stream.
// - The byte stream feeds the UART TX AXI-Stream slave port (8-bit tdata) directly downstream.
// - Frame: SYNC_BYTE, LEN (words per packet), payload bytes LSB-first, optional checksum byte.

---
 rtl/axis_word_packetizer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/axis_word_packetizer.sv
// Frames WORD_WIDTH-bit result words into a SYNC/LEN/payload byte stream for the UART TX port.
// Define PKT_CHECKSUM_EN to append a two's-complement checksum byte to every packet.
module axis_word_packetizer #(
  parameter int         WORD_WIDTH    = 32,
  parameter int         WORDS_PER_PKT = 16,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         CNT_WIDTH     = 8
) (
  input  logic                  aclk,
  input  logic                  arstn,
  input  logic [WORD_WIDTH-1:0] s_word_tdata,
  input  logic                  s_word_tvalid,
  output logic                  s_word_tready,
  output logic [7:0]            m_byte_tdata,
  output logic                  m_byte_tvalid,
  input  logic                  m_byte_tready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  localparam int             BPW       = WORD_WIDTH / 8;
  localparam int             BIW       = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [7:0]     LEN_BYTE  = 8'(WORDS_PER_PKT);
  localparam logic [7:0]     LAST_WORD = 8'(WORDS_PER_PKT - 1);
  localparam logic [BIW-1:0] LAST_BYTE = BIW'(BPW - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_LOAD = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd5
`ifdef PKT_CHECKSUM_EN
    , ST_CSUM = 3'd4
`endif
  } state_t;

`ifdef PKT_CHECKSUM_EN
  localparam state_t END_ST = ST_CSUM;

  function automatic logic [7:0] csum_byte(input logic [7:0] sum);
    return ~sum + 8'd1;
  endfunction
`else
  localparam state_t END_ST = ST_DONE;
`endif

  state_t                state_r, state_nxt_s;
  logic [7:0]            m_byte_tdata_r;
  logic                  m_byte_tvalid_r;
  logic [WORD_WIDTH-1:0] shift_r;
  logic [BIW-1:0]        byte_idx_r;
  logic [7:0]            word_idx_r;
  logic [CNT_WIDTH-1:0]  pkt_count_r;
  logic                  load_s;
  logic [7:0]            load_byte_s;
  logic                  slot_free_s, word_hs_s, last_word_s, last_byte_s;
`ifdef PKT_CHECKSUM_EN
  logic [7:0]            sum_r;
`endif

  // The output slot accepts a new byte when empty or draining this cycle.
  assign slot_free_s   = !m_byte_tvalid_r || m_byte_tready;
  assign s_word_tready = (state_r == ST_LOAD) && slot_free_s;
  assign word_hs_s     = s_word_tvalid && s_word_tready;
  assign last_word_s   = (word_idx_r == LAST_WORD);
  assign last_byte_s   = (byte_idx_r == LAST_BYTE);
  assign m_byte_tdata  = m_byte_tdata_r;
  assign m_byte_tvalid = m_byte_tvalid_r;
  assign busy          = (state_r != ST_IDLE);
  assign pkt_count     = pkt_count_r;

  // State register.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: if (slot_free_s && s_word_tvalid) state_nxt_s = ST_LEN; else state_nxt_s = state_r;
      ST_LEN:  if (slot_free_s) state_nxt_s = ST_LOAD; else state_nxt_s = state_r;
      ST_LOAD: begin
        if (!word_hs_s)       state_nxt_s = state_r;
        else if (BPW > 1)     state_nxt_s = ST_DATA;
        else if (last_word_s) state_nxt_s = END_ST;
        else                  state_nxt_s = ST_LOAD;
      end
      ST_DATA: begin
        if (!(slot_free_s && last_byte_s)) state_nxt_s = state_r;
        else if (last_word_s)              state_nxt_s = END_ST;
        else                               state_nxt_s = ST_LOAD;
      end
`ifdef PKT_CHECKSUM_EN
      ST_CSUM: if (slot_free_s) state_nxt_s = ST_DONE; else state_nxt_s = state_r;
`endif
      ST_DONE: if (m_byte_tvalid_r && m_byte_tready) state_nxt_s = ST_IDLE; else state_nxt_s = state_r;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Which byte, if any, enters the output slot this cycle.
  always_comb begin
    load_s      = 1'b0;
    load_byte_s = 8'h00;
    case (state_r)
      ST_IDLE: begin load_s = slot_free_s && s_word_tvalid; load_byte_s = SYNC_BYTE; end
      ST_LEN:  begin load_s = slot_free_s; load_byte_s = LEN_BYTE; end
      ST_LOAD: begin load_s = word_hs_s; load_byte_s = s_word_tdata[7:0]; end
      ST_DATA: begin load_s = slot_free_s; load_byte_s = shift_r[7:0]; end
`ifdef PKT_CHECKSUM_EN
      ST_CSUM: begin load_s = slot_free_s; load_byte_s = csum_byte(sum_r); end
`endif
      default: begin load_s = 1'b0; load_byte_s = 8'h00; end
    endcase
  end

  // Output slot, word/byte indices, shift register and packet counter.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      m_byte_tdata_r  <= 8'h00;
      m_byte_tvalid_r <= 1'b0;
      shift_r         <= '0;
      byte_idx_r      <= '0;
      word_idx_r      <= 8'd0;
      pkt_count_r     <= '0;
    end else begin
      if (slot_free_s) begin
        m_byte_tvalid_r <= load_s;
        if (load_s) m_byte_tdata_r <= load_byte_s;
      end
      case (state_r)
        ST_LEN: if (slot_free_s) begin
          byte_idx_r <= '0;
          word_idx_r <= 8'd0;
        end
        ST_LOAD: if (word_hs_s) begin
          shift_r    <= s_word_tdata >> 4'd8;
          byte_idx_r <= BIW'(1);
          if (BPW == 1) word_idx_r <= word_idx_r + 8'd1;
        end
        ST_DATA: if (slot_free_s) begin
          shift_r <= shift_r >> 4'd8;
          if (last_byte_s) begin
            byte_idx_r <= '0;
            word_idx_r <= word_idx_r + 8'd1;
          end else begin
            byte_idx_r <= byte_idx_r + BIW'(1);
          end
        end
        ST_DONE: if (m_byte_tvalid_r && m_byte_tready) pkt_count_r <= pkt_count_r + CNT_WIDTH'(1);
        default: ;
      endcase
    end
  end

`ifdef PKT_CHECKSUM_EN
  // Running 8-bit sum over LEN and every payload byte.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      sum_r <= 8'h00;
    end else begin
      case (state_r)
        ST_LEN:           if (slot_free_s) sum_r <= LEN_BYTE;
        ST_LOAD, ST_DATA: if (load_s) sum_r <= sum_r + load_byte_s;
        default: ;
      endcase
    end
  end
`endif

endmodule
